// File: rtl/bf_prog_loader.sv
// Brainfuck program loader: debounced opcode keying, bracket jump table, run handoff.
// Optional LED echo on dbg enabled by defining BF_LOADER_ECHO_EN.
module bf_prog_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEBOUNCE    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [7:0]        sw,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        rd_op,
  output logic [ADDR_W-1:0] rd_jmp,
  output logic [ADDR_W:0]   prog_len,
  output logic              loading,
  output logic              start,
  output logic [1:0]        err,
  output logic [7:0]        dbg
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [2:0] OP_OPEN  = 3'd6;
  localparam logic [2:0] OP_CLOSE = 3'd7;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERR} state_t;

  state_t            state, state_n;
  logic [1:0]        err_n;
  logic [LEN_W-1:0]  len_n;
  logic [SP_W-1:0]   sp, sp_n;
  logic              start_n;
  logic              do_write, do_push, do_pop;

  logic              push_s1, push_s2, push_q;
  logic              sw7_s1, sw7_s2, sw7_q;
  logic              stable_push, stable_q;
  logic [CNT_W-1:0]  db_cnt;
  logic [2:0]        op_hold;
  logic              accept, sw7_rise, sw7_fall;

  logic [2:0]        mem_op [DEPTH];
  logic [ADDR_W-1:0] jmp    [DEPTH];
  logic [ADDR_W-1:0] stack  [STACK_DEPTH];
  logic [ADDR_W-1:0] waddr, top;

  logic unused_sw;
  assign unused_sw = ^sw[6:3];

  // Input synchronizers, edge history and opcode capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_s1 <= 1'b0;
      push_s2 <= 1'b0;
      push_q  <= 1'b0;
      sw7_s1  <= 1'b0;
      sw7_s2  <= 1'b0;
      sw7_q   <= 1'b0;
      op_hold <= 3'd0;
    end else begin
      push_s1 <= push;
      push_s2 <= push_s1;
      push_q  <= push_s2;
      sw7_s1  <= sw[7];
      sw7_s2  <= sw7_s1;
      sw7_q   <= sw7_s2;
      if (push_s2 && !push_q) op_hold <= sw[2:0];
    end
  end

  // Debounce: a level must differ from stable_push for DEBOUNCE straight cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_push <= 1'b0;
      stable_q    <= 1'b0;
      db_cnt      <= '0;
    end else begin
      stable_q <= stable_push;
      if (push_s2 != stable_push) begin
        if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
          stable_push <= push_s2;
          db_cnt      <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign accept   = stable_push && !stable_q;
  assign sw7_rise = sw7_s2 && !sw7_q;
  assign sw7_fall = !sw7_s2 && sw7_q;
  assign waddr    = prog_len[ADDR_W-1:0];
  assign top      = stack[STK_W'(sp - SP_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      err      <= 2'd0;
      prog_len <= '0;
      sp       <= '0;
      start    <= 1'b0;
      loading  <= 1'b1;
    end else begin
      state    <= state_n;
      err      <= err_n;
      prog_len <= len_n;
      sp       <= sp_n;
      start    <= start_n;
      loading  <= (state_n == S_LOAD);
    end
  end

  // Run check sees len_n/sp_n so a same-cycle accept is already applied
  always_comb begin
    state_n  = state;
    err_n    = err;
    len_n    = prog_len;
    sp_n     = sp;
    start_n  = 1'b0;
    do_write = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    unique case (state)
      S_LOAD: begin
        if (accept) begin
          if (prog_len == LEN_W'(DEPTH)) begin
            err_n   = 2'd3;
            state_n = S_ERR;
          end else if (op_hold == OP_OPEN && sp == SP_W'(STACK_DEPTH)) begin
            err_n   = 2'd3;
            state_n = S_ERR;
          end else if (op_hold == OP_CLOSE && sp == '0) begin
            err_n   = 2'd2;
            state_n = S_ERR;
          end else begin
            do_write = 1'b1;
            len_n    = prog_len + LEN_W'(1);
            if (op_hold == OP_OPEN) begin
              do_push = 1'b1;
              sp_n    = sp + SP_W'(1);
            end
            if (op_hold == OP_CLOSE) begin
              do_pop = 1'b1;
              sp_n   = sp - SP_W'(1);
            end
          end
        end
        if (state_n == S_LOAD && sw7_rise) begin
          if (sp_n != '0) begin
            err_n   = 2'd1;
            state_n = S_ERR;
          end else if (len_n != '0) begin
            start_n = 1'b1;
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (sw7_fall) begin
          state_n = S_LOAD;
          len_n   = '0;
          sp_n    = '0;
        end
      end
      S_ERR: begin
      end
      default: state_n = S_LOAD;
    endcase
  end

  // Program, jump table and bracket stack storage
  always_ff @(posedge clk) begin
    if (do_write) mem_op[waddr] <= op_hold;
    if (do_push) stack[STK_W'(sp)] <= waddr;
    if (do_pop) begin
      jmp[top]   <= waddr;
      jmp[waddr] <= top;
    end
  end

  assign rd_op  = mem_op[rd_addr];
  assign rd_jmp = jmp[rd_addr];

`ifdef BF_LOADER_ECHO_EN
  // LED echo of the last stored opcode and running length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg <= 8'd0;
    else if (do_write) dbg <= {op_hold, 5'(len_n)};
  end
`else
  assign dbg = 8'd0;
`endif

endmodule

// File: tb/tb_bf_prog_loader.sv
// Randomized and directed bench for bf_prog_loader against a program-list reference model.
module tb_bf_prog_loader;

  localparam int AW    = 5;
  localparam int SD    = 16;
  localparam int DB    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int M_LOAD = 0, M_RUN = 1, M_ERR = 2;

  logic          clk, rst_n, push;
  logic [7:0]    sw;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_op;
  logic [AW-1:0] rd_jmp;
  logic [AW:0]   prog_len;
  logic          loading, start;
  logic [1:0]    err;
  logic [7:0]    dbg;

  bf_prog_loader #(.ADDR_W(AW), .STACK_DEPTH(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .sw(sw), .rd_addr(rd_addr),
    .rd_op(rd_op), .rd_jmp(rd_jmp), .prog_len(prog_len), .loading(loading),
    .start(start), .err(err), .dbg(dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int starts = 0;

  always @(negedge clk) if (start === 1'b1) starts++;

  // Reference model: the program as a list plus error/state
  int m_prog[$];
  int m_err;
  int m_state;
  int m_dbg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int depth_now();
    int d = 0;
    foreach (m_prog[i]) begin
      if (m_prog[i] == 6) d++;
      if (m_prog[i] == 7) d--;
    end
    return d;
  endfunction

  function automatic int match(input int i);
    int d = 0;
    if (m_prog[i] == 6) begin
      for (int j = i; j < m_prog.size(); j++) begin
        if (m_prog[j] == 6) d++;
        if (m_prog[j] == 7) d--;
        if (d == 0) return j;
      end
    end else begin
      for (int j = i; j >= 0; j--) begin
        if (m_prog[j] == 7) d++;
        if (m_prog[j] == 6) d--;
        if (d == 0) return j;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_prog.delete();
    m_err = 0;
    m_state = M_LOAD;
    m_dbg = 0;
  endfunction

  function automatic void model_accept(input int op);
    if (m_state != M_LOAD) return;
    if (m_prog.size() == DEPTH) begin
      m_err = 3; m_state = M_ERR;
    end else if (op == 7 && depth_now() == 0) begin
      m_err = 2; m_state = M_ERR;
    end else if (op == 6 && depth_now() == SD) begin
      m_err = 3; m_state = M_ERR;
    end else begin
      m_prog.push_back(op);
      m_dbg = (op << 5) | (m_prog.size() % 32);
    end
  endfunction

  function automatic int model_rise();
    if (m_state != M_LOAD) return 0;
    if (depth_now() > 0) begin
      m_err = 1; m_state = M_ERR;
      return 0;
    end
    if (m_prog.size() > 0) begin
      m_state = M_RUN;
      return 1;
    end
    return 0;
  endfunction

  task automatic do_reset();
    push = 1'b0; sw = 8'd0; rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    model_reset();
  endtask

  task automatic press(input int op, input int hold);
    sw[2:0] = 3'(op);
    push = 1'b1;
    cyc(hold);
    push = 1'b0;
    cyc(7);
    if (hold >= DB) model_accept(op);
  endtask

  task automatic run_up(input string tag);
    int s0 = starts;
    int e;
    sw[7] = 1'b1;
    cyc(6);
    e = model_rise();
    chk({tag, "_start"}, 32'(starts - s0), 32'(e));
  endtask

  task automatic run_down();
    sw[7] = 1'b0;
    cyc(6);
    if (m_state == M_RUN) begin
      m_state = M_LOAD;
      m_prog.delete();
    end
  endtask

  task automatic check_state(input string tag);
    int m;
    chk({tag, "_len"}, 32'(prog_len), 32'(m_prog.size()));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_loading"}, 32'(loading), 32'(m_state == M_LOAD));
`ifdef BF_LOADER_ECHO_EN
    chk({tag, "_dbg"}, 32'(dbg), 32'(m_dbg));
`else
    chk({tag, "_dbg"}, 32'(dbg), 32'd0);
`endif
    foreach (m_prog[i]) begin
      rd_addr = AW'(i);
      #1;
      chk({tag, "_op"}, 32'(rd_op), 32'(m_prog[i]));
      if (m_prog[i] >= 6) begin
        m = match(i);
        if (m >= 0) chk({tag, "_jmp"}, 32'(rd_jmp), 32'(m));
      end
    end
  endtask

  initial begin
    int n, op, hold, s0;
    rd_addr = '0;
    do_reset();
    chk("rst_start", 32'(start), 32'd0);
    check_state("rst");

    // "+[-]" with write-latency check on the first press
    sw[2:0] = 3'd0;
    push = 1'b1;
    cyc(2);
    push = 1'b0;
    cyc(2);
    chk("lat_before", 32'(prog_len), 32'd0);
    cyc(1);
    chk("lat_after", 32'(prog_len), 32'd1);
    cyc(4);
    model_accept(0);
    press(6, 2); press(1, 2); press(7, 2);
    run_up("plus_loop");
    check_state("plus_loop");
    rd_addr = AW'(1); #1; chk("jmp1", 32'(rd_jmp), 32'd3);
    rd_addr = AW'(3); #1; chk("jmp3", 32'(rd_jmp), 32'd1);
    rd_addr = AW'(2); #1; chk("op2", 32'(rd_op), 32'd1);
    press(2, 3);
    check_state("run_ignores_push");
    run_down();
    check_state("back_to_load");

    // Leading ']' locks up in ERR
    do_reset();
    press(7, 2); press(0, 2);
    run_up("close_first");
    check_state("close_first");

    // Unbalanced '[' at run
    do_reset();
    press(6, 2); press(6, 2); press(7, 2);
    run_up("unmatched_open");
    check_state("unmatched_open");

    // One-cycle glitch is rejected
    do_reset();
    press(4, 1);
    check_state("glitch");
    press(4, 2);
    check_state("clean");

    // Program overflow
    do_reset();
    for (int i = 0; i <= DEPTH; i++) press(0, 2);
    check_state("prog_ovf");

    // Stack overflow
    do_reset();
    for (int i = 0; i <= SD; i++) press(6, 2);
    check_state("stack_ovf");

    // Accept and run edge in the same cycle: closing ']' counted first
    do_reset();
    press(6, 2);
    s0 = starts;
    sw[2:0] = 3'd7;
    push = 1'b1;
    cyc(2);
    push = 1'b0;
    sw[7] = 1'b1;
    cyc(7);
    model_accept(7);
    chk("same_cycle_start", 32'(starts - s0), 32'(model_rise()));
    check_state("same_cycle");
    run_down();

    // Reset mid-load discards in-flight press
    do_reset();
    press(1, 2); press(2, 2); press(3, 2);
    sw[2:0] = 3'd5;
    push = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    push = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    model_reset();
    check_state("mid_reset");
    press(4, 2);
    check_state("after_mid_reset");

    // Randomized programs
    for (int r = 0; r < 10; r++) begin
      do_reset();
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(0, 7);
        hold = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 4);
        press(op, hold);
      end
      check_state("rnd_load");
      run_up("rnd");
      check_state("rnd_run");
      run_down();
      check_state("rnd_down");
      press($urandom_range(0, 5), 2);
      check_state("rnd_reload");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
